// File: rtl/mips_program_loader.sv
// mips_program_loader
//   Stream-driven boot/debug loader for the pipelined MIPS core. Words arrive
//   over a valid/ready stream. In IDLE each word is decoded as a command
//   (opcode [31:28], count [27:16], base [15:0]). Load commands switch to a
//   payload state in which each word is written to instruction or data
//   memory at an auto-incrementing, wrapping word address. The loader also
//   holds the core in reset (cpuHold) until a run command arrives.
//
// Ports
//   clock, resetMachine      : clock and synchronous active-high reset
//   loadValid/loadData/      : input word stream; loadReady is low only
//   loadReady                  during the reset cycle
//   imemWriteEnable/Address  : instruction-memory write port (registered)
//   dmemWriteEnable/Address  : data-memory write port (registered)
//   memWriteData             : write data shared by both memories
//   cpuHold                  : pipeline hold request, set out of reset
//   loaderBusy               : high while payload words are outstanding
//   errorFlag                : sticky protocol error, cleared by reset only
//   wordsWritten             : saturating count of payload words written
module mips_program_loader #(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clock,
    input  logic                       resetMachine,
    input  logic                       loadValid,
    input  logic [31:0]                loadData,
    output logic                       loadReady,
    output logic                       imemWriteEnable,
    output logic [IMEM_ADDR_WIDTH-1:0] imemWriteAddress,
    output logic                       dmemWriteEnable,
    output logic [DMEM_ADDR_WIDTH-1:0] dmemWriteAddress,
    output logic [31:0]                memWriteData,
    output logic                       cpuHold,
    output logic                       loaderBusy,
    output logic                       errorFlag,
    output logic [15:0]                wordsWritten
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_IMEM,
        ST_LOAD_DMEM
    } state_t;

    localparam logic [3:0] OP_LOAD_IMEM = 4'h1;
    localparam logic [3:0] OP_LOAD_DMEM = 4'h2;
    localparam logic [3:0] OP_RUN       = 4'h3;
    localparam logic [3:0] OP_HALT      = 4'h4;

    localparam logic [IMEM_ADDR_WIDTH-1:0] IMEM_ONE = 1;
    localparam logic [DMEM_ADDR_WIDTH-1:0] DMEM_ONE = 1;

    state_t                     state_q, state_d;
    logic [11:0]                remaining_q, remaining_d;
    logic [IMEM_ADDR_WIDTH-1:0] imem_ptr_q, imem_ptr_d;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_ptr_q, dmem_ptr_d;
    logic                       imem_we_q, imem_we_d;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic                       dmem_we_q, dmem_we_d;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       hold_q, hold_d;
    logic                       error_q, error_d;
    logic [15:0]                words_q, words_d;

    logic        accept;
    logic [3:0]  opcode;
    logic [11:0] count;
    logic [15:0] base;

    assign loadReady = ~resetMachine;
    assign accept    = loadValid & loadReady;
    assign opcode    = loadData[31:28];
    assign count     = loadData[27:16];
    assign base      = loadData[15:0];

    always_ff @(posedge clock) begin
        if (resetMachine) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            imem_ptr_q  <= '0;
            dmem_ptr_q  <= '0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            wdata_q     <= '0;
            hold_q      <= 1'b1;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            imem_ptr_q  <= imem_ptr_d;
            dmem_ptr_q  <= dmem_ptr_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        imem_ptr_d  = imem_ptr_q;
        dmem_ptr_d  = dmem_ptr_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        dmem_we_d   = 1'b0;
        dmem_addr_d = dmem_addr_q;
        wdata_d     = wdata_q;
        hold_d      = hold_q;
        error_d     = error_q;
        words_d     = words_q;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (opcode)
                        OP_LOAD_IMEM: begin
                            // Loading into a running core is rejected before the
                            // count is looked at, so a zero-count load is an error too.
                            if (!hold_q) begin
                                error_d = 1'b1;
                            end else if (count != 12'd0) begin
                                imem_ptr_d  = base[IMEM_ADDR_WIDTH-1:0];
                                remaining_d = count;
                                state_d     = ST_LOAD_IMEM;
                            end
                        end
                        OP_LOAD_DMEM: begin
                            if (!hold_q) begin
                                error_d = 1'b1;
                            end else if (count != 12'd0) begin
                                dmem_ptr_d  = base[DMEM_ADDR_WIDTH-1:0];
                                remaining_d = count;
                                state_d     = ST_LOAD_DMEM;
                            end
                        end
                        OP_RUN:  hold_d  = 1'b0;
                        OP_HALT: hold_d  = 1'b1;
                        default: error_d = 1'b1;
                    endcase
                end
                ST_LOAD_IMEM, ST_LOAD_DMEM: begin
                    wdata_d = loadData;
                    if (state_q == ST_LOAD_IMEM) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = imem_ptr_q;
                        imem_ptr_d  = imem_ptr_q + IMEM_ONE;
                    end else begin
                        dmem_we_d   = 1'b1;
                        dmem_addr_d = dmem_ptr_q;
                        dmem_ptr_d  = dmem_ptr_q + DMEM_ONE;
                    end
                    if (words_q != 16'hFFFF) begin
                        words_d = words_q + 16'd1;
                    end
                    remaining_d = remaining_q - 12'd1;
                    if (remaining_q == 12'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign imemWriteEnable  = imem_we_q;
    assign imemWriteAddress = imem_addr_q;
    assign dmemWriteEnable  = dmem_we_q;
    assign dmemWriteAddress = dmem_addr_q;
    assign memWriteData     = wdata_q;
    assign cpuHold          = hold_q;
    assign loaderBusy       = (state_q != ST_IDLE);
    assign errorFlag        = error_q;
    assign wordsWritten     = words_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// tb_mips_program_loader
//   Directed bench for mips_program_loader: reset values, IMEM load,
//   run/halt, DMEM wrap with stalls, zero-count load, protocol errors and
//   reset in the middle of a load. Each step drives one cycle of stimulus
//   on the falling edge and checks registered outputs 1 time unit after
//   the following rising edge.
module tb_mips_program_loader;

    logic        clock;
    logic        resetMachine;
    logic        loadValid;
    logic [31:0] loadData;
    logic        loadReady;
    logic        imemWriteEnable;
    logic [9:0]  imemWriteAddress;
    logic        dmemWriteEnable;
    logic [9:0]  dmemWriteAddress;
    logic [31:0] memWriteData;
    logic        cpuHold;
    logic        loaderBusy;
    logic        errorFlag;
    logic [15:0] wordsWritten;

    int total = 0;
    int bad   = 0;

    mips_program_loader #(
        .IMEM_ADDR_WIDTH(10),
        .DMEM_ADDR_WIDTH(10)
    ) dut (
        .clock           (clock),
        .resetMachine    (resetMachine),
        .loadValid       (loadValid),
        .loadData        (loadData),
        .loadReady       (loadReady),
        .imemWriteEnable (imemWriteEnable),
        .imemWriteAddress(imemWriteAddress),
        .dmemWriteEnable (dmemWriteEnable),
        .dmemWriteAddress(dmemWriteAddress),
        .memWriteData    (memWriteData),
        .cpuHold         (cpuHold),
        .loaderBusy      (loaderBusy),
        .errorFlag       (errorFlag),
        .wordsWritten    (wordsWritten)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle: drive on the falling edge, return just after the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [31:0] d);
        @(negedge clock);
        resetMachine = r;
        loadValid    = v;
        loadData     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".imem_we"},   {31'd0, imemWriteEnable}, 32'd0);
        chk({tag, ".imem_addr"}, {22'd0, imemWriteAddress}, 32'd0);
        chk({tag, ".dmem_we"},   {31'd0, dmemWriteEnable}, 32'd0);
        chk({tag, ".dmem_addr"}, {22'd0, dmemWriteAddress}, 32'd0);
        chk({tag, ".wdata"},     memWriteData, 32'd0);
        chk({tag, ".hold"},      {31'd0, cpuHold}, 32'd1);
        chk({tag, ".busy"},      {31'd0, loaderBusy}, 32'd0);
        chk({tag, ".err"},       {31'd0, errorFlag}, 32'd0);
        chk({tag, ".words"},     {16'd0, wordsWritten}, 32'd0);
    endtask

    initial begin
        resetMachine = 1'b1;
        loadValid    = 1'b0;
        loadData     = '0;

        // Reset
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h3000_0000);   // offered during reset: must be ignored
        chk("rst.ready", {31'd0, loadReady}, 32'd0);
        chk_reset_values("rst");
        cyc(1'b0, 1'b0, 32'h0);
        chk("rst.ready_after", {31'd0, loadReady}, 32'd1);
        chk("rst.hold_after", {31'd0, cpuHold}, 32'd1);

        // IMEM load: 3 words at base 4
        cyc(1'b0, 1'b1, 32'h1003_0004);
        chk("imem.busy0", {31'd0, loaderBusy}, 32'd1);
        chk("imem.we0", {31'd0, imemWriteEnable}, 32'd0);
        cyc(1'b0, 1'b1, 32'h8C00_0000);
        chk("imem.we1", {31'd0, imemWriteEnable}, 32'd1);
        chk("imem.addr1", {22'd0, imemWriteAddress}, 32'd4);
        chk("imem.data1", memWriteData, 32'h8C00_0000);
        cyc(1'b0, 1'b1, 32'h8C02_0008);
        chk("imem.we2", {31'd0, imemWriteEnable}, 32'd1);
        chk("imem.addr2", {22'd0, imemWriteAddress}, 32'd5);
        chk("imem.data2", memWriteData, 32'h8C02_0008);
        chk("imem.busy2", {31'd0, loaderBusy}, 32'd1);
        cyc(1'b0, 1'b1, 32'h8C04_0009);
        chk("imem.we3", {31'd0, imemWriteEnable}, 32'd1);
        chk("imem.addr3", {22'd0, imemWriteAddress}, 32'd6);
        chk("imem.data3", memWriteData, 32'h8C04_0009);
        chk("imem.busy3", {31'd0, loaderBusy}, 32'd0);
        chk("imem.words", {16'd0, wordsWritten}, 32'd3);
        chk("imem.hold", {31'd0, cpuHold}, 32'd1);
        chk("imem.dmem_we", {31'd0, dmemWriteEnable}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("imem.we_off", {31'd0, imemWriteEnable}, 32'd0);

        // Run / halt
        cyc(1'b0, 1'b1, 32'h3000_0000);
        chk("run.hold", {31'd0, cpuHold}, 32'd0);
        cyc(1'b0, 1'b1, 32'h4000_0000);
        chk("halt.hold", {31'd0, cpuHold}, 32'd1);

        // DMEM wrap with a 3-cycle gap
        cyc(1'b0, 1'b1, 32'h2002_03FF);
        chk("dmem.busy0", {31'd0, loaderBusy}, 32'd1);
        cyc(1'b0, 1'b1, 32'hC0CA_C01A);
        chk("dmem.we1", {31'd0, dmemWriteEnable}, 32'd1);
        chk("dmem.addr1", {22'd0, dmemWriteAddress}, 32'h3FF);
        chk("dmem.data1", memWriteData, 32'hC0CA_C01A);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'hDEAD_BEEF);
            chk("dmem.gap_we", {31'd0, dmemWriteEnable}, 32'd0);
            chk("dmem.gap_busy", {31'd0, loaderBusy}, 32'd1);
        end
        cyc(1'b0, 1'b1, 32'h1042_AABB);
        chk("dmem.we2", {31'd0, dmemWriteEnable}, 32'd1);
        chk("dmem.addr2", {22'd0, dmemWriteAddress}, 32'h000);
        chk("dmem.data2", memWriteData, 32'h1042_AABB);
        chk("dmem.imem_we", {31'd0, imemWriteEnable}, 32'd0);
        chk("dmem.busy2", {31'd0, loaderBusy}, 32'd0);
        chk("dmem.words", {16'd0, wordsWritten}, 32'd5);

        // Zero-count load is a no-op; next word is a command
        cyc(1'b0, 1'b1, 32'h1000_0010);
        chk("zero.busy", {31'd0, loaderBusy}, 32'd0);
        chk("zero.we", {31'd0, imemWriteEnable}, 32'd0);
        cyc(1'b0, 1'b1, 32'h3000_0000);
        chk("zero.run", {31'd0, cpuHold}, 32'd0);
        chk("zero.err", {31'd0, errorFlag}, 32'd0);
        chk("zero.words", {16'd0, wordsWritten}, 32'd5);
        cyc(1'b0, 1'b1, 32'h4000_0000);
        chk("zero.halt", {31'd0, cpuHold}, 32'd1);

        // Bad opcode
        cyc(1'b0, 1'b1, 32'h9000_0000);
        chk("err.op_flag", {31'd0, errorFlag}, 32'd1);
        chk("err.op_busy", {31'd0, loaderBusy}, 32'd0);
        chk("err.op_we", {31'd0, imemWriteEnable | dmemWriteEnable}, 32'd0);

        // Load while running
        cyc(1'b0, 1'b1, 32'h3000_0000);
        chk("err.run_hold", {31'd0, cpuHold}, 32'd0);
        cyc(1'b0, 1'b1, 32'h1001_0000);
        chk("err.load_flag", {31'd0, errorFlag}, 32'd1);
        chk("err.load_busy", {31'd0, loaderBusy}, 32'd0);
        cyc(1'b0, 1'b1, 32'h4000_0000);   // decoded as halt, not payload
        chk("err.follow_we", {31'd0, imemWriteEnable}, 32'd0);
        chk("err.follow_hold", {31'd0, cpuHold}, 32'd1);
        chk("err.sticky", {31'd0, errorFlag}, 32'd1);
        chk("err.words", {16'd0, wordsWritten}, 32'd5);

        // Reset clears the sticky error
        cyc(1'b1, 1'b0, 32'h0);
        chk_reset_values("rst2");

        // Reset mid-load
        cyc(1'b0, 1'b1, 32'h1005_0000);
        chk("mid.busy0", {31'd0, loaderBusy}, 32'd1);
        cyc(1'b0, 1'b1, 32'h1111_1111);
        chk("mid.addr1", {22'd0, imemWriteAddress}, 32'd0);
        chk("mid.we1", {31'd0, imemWriteEnable}, 32'd1);
        cyc(1'b0, 1'b1, 32'h2222_2222);
        chk("mid.addr2", {22'd0, imemWriteAddress}, 32'd1);
        chk("mid.words2", {16'd0, wordsWritten}, 32'd2);
        cyc(1'b1, 1'b1, 32'h3333_3333);
        chk("mid.ready", {31'd0, loadReady}, 32'd0);
        chk_reset_values("mid.rst");
        cyc(1'b0, 1'b1, 32'h3000_0000);
        chk("mid.run_hold", {31'd0, cpuHold}, 32'd0);
        chk("mid.run_busy", {31'd0, loaderBusy}, 32'd0);
        chk("mid.run_we", {31'd0, imemWriteEnable}, 32'd0);
        cyc(1'b0, 1'b1, 32'h4000_0000);
        chk("mid.next_we", {31'd0, imemWriteEnable}, 32'd0);
        chk("mid.next_hold", {31'd0, cpuHold}, 32'd1);
        chk("mid.words", {16'd0, wordsWritten}, 32'd0);
        chk("mid.err", {31'd0, errorFlag}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
